// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, round count and key-schedule FSM states.
// AES_KEYSCHED_SBOX_PIPE_EN adds the SUB state used by the pipelined SubWord variant.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
`ifdef AES_KEYSCHED_SBOX_PIPE_EN
        SUB    = 2'd2,
`endif
        READY  = 2'd3
    } ks_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion into an 11-slot round-key store with a registered read port.
// Define AES_KEYSCHED_SBOX_PIPE_EN to register SubWord, making each round take two cycles.
module aes_key_schedule_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_e    state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic [127:0] store_q [0:NR];
    logic [127:0] rd_key_q;

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  sub_in, sub_out, temp;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] round_key;

    assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign prev_key = store_q[prev_idx];
    assign sub_in   = {prev_key[23:0], prev_key[31:24]};

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

`ifdef AES_KEYSCHED_SBOX_PIPE_EN
    logic [31:0] sub_q;

    // Source slot is stable across EXPAND and SUB, so only SubWord needs holding.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sub_q <= '0;
        end else if (state_q == EXPAND) begin
            sub_q <= sub_out;
        end
    end

    assign temp = sub_q ^ {rcon(rnd_q), 24'h0};
`else
    assign temp = sub_out ^ {rcon(rnd_q), 24'h0};
`endif

    assign w0_n      = prev_key[127:96] ^ temp;
    assign w1_n      = prev_key[95:64]  ^ w0_n;
    assign w2_n      = prev_key[63:32]  ^ w1_n;
    assign w3_n      = prev_key[31:0]   ^ w2_n;
    assign round_key = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        case (state_q)
            IDLE, READY: begin
                if (key_valid) begin
                    wr_en   = 1'b1;
                    wr_data = key_in;
                    rnd_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
`ifdef AES_KEYSCHED_SBOX_PIPE_EN
            EXPAND: begin
                state_d = SUB;
            end
            SUB: begin
`else
            EXPAND: begin
`endif
                wr_en   = 1'b1;
                wr_idx  = rnd_q;
                wr_data = round_key;
                rnd_d   = rnd_q + 4'd1;
`ifdef AES_KEYSCHED_SBOX_PIPE_EN
                state_d = EXPAND;
`endif
                if (rnd_q == LAST_RND) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    // Store is deliberately left uncleared by reset; reset only blocks the write.
    always_ff @(posedge CLK) begin
        if (wr_en && !RST) begin
            store_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_key_q <= '0;
        end else if (rd_idx <= LAST_RND) begin
            rd_key_q <= store_q[rd_idx];
        end else begin
            rd_key_q <= '0;
        end
    end

    assign key_ready  = (state_q == IDLE) || (state_q == READY);
    assign keys_valid = (state_q == READY);
    assign busy       = !key_ready;
    assign done       = done_q;
    assign rd_key     = rd_key_q;

endmodule
